layer_write_scheduler: RTL and testbench

- Sequences all write traffic into the three drawing-layer frame memories.
- Two engines share one write port:
  - a full-screen clear sweep per layer mask;
  - a brush-stamp walker that emits one pixel of a square brush per cycle.
- Sits between the cursor/input logic and the layer RAMs. It replaces per-scan-pixel write gating with an explicit, arbitrated write stream.

---
 rtl/layer_write_scheduler.sv | 162 ++++++++++++++++
 tb/tb_layer_write_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_write_scheduler.sv
// Arbitrated write stream into the three drawing-layer frame memories:
// full-screen clear sweeps and square brush stamps share one registered write port.
module layer_write_scheduler #(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned CLEAR_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [2:0]        clear_mask,
    input  logic              stamp_valid,
    output logic              stamp_ready,
    input  logic [9:0]        cursor_x,
    input  logic [9:0]        cursor_y,
    input  logic [1:0]        cursor_size,
    input  logic [2:0]        layer_mask,
    input  logic              eraser,
    input  logic [DATA_W-1:0] pen_data,
    output logic [9:0]        wr_x,
    output logic [9:0]        wr_y,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        we_layer,
    output logic              busy
);

    localparam logic [9:0]        XLast  = 10'(H_RES - 1);
    localparam logic [9:0]        YLast  = 10'(V_RES - 1);
    localparam logic [10:0]       XLimit = 11'(H_RES);
    localparam logic [10:0]       YLimit = 11'(V_RES);
    localparam logic [DATA_W-1:0] ClrVal = DATA_W'(CLEAR_VAL);

    typedef enum logic [1:0] {StIdle, StClear, StStamp} state_e;

    state_e              state_q;
    logic [2:0]          pend_q;
    logic [2:0]          act_q;
    logic [9:0]          base_x_q;
    logic [9:0]          base_y_q;
    logic [4:0]          n_q;
    logic [4:0]          off_x_q;
    logic [4:0]          off_y_q;
    logic [2:0]          smask_q;
    logic [DATA_W-1:0]   sdata_q;

    logic [2:0]          req_bits;
    logic [4:0]          size_n;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_on;
    logic [4:0]          n_last;
    logic                row_end;
    logic                stamp_done;
    logic [4:0]          nx_off_x;
    logic [4:0]          nx_off_y;
    logic [10:0]         sum_x;
    logic [10:0]         sum_y;
    logic                sum_on;

    always_comb begin
        req_bits    = clear_req ? clear_mask : 3'b000;
        // A clear arriving this cycle already blocks a stamp, giving clear priority.
        stamp_ready = (state_q == StIdle) && ((pend_q | req_bits) == 3'b000) && !reset;
        busy        = !reset && ((state_q != StIdle) || (pend_q != 3'b000));

        unique case (cursor_size)
            2'b00:   size_n = 5'd4;
            2'b01:   size_n = 5'd8;
            2'b10:   size_n = 5'd20;
            default: size_n = 5'd0;
        endcase
        acc_data = eraser ? ClrVal : pen_data;
        acc_on   = ({1'b0, cursor_x} < XLimit) && ({1'b0, cursor_y} < YLimit);

        n_last     = n_q - 5'd1;
        row_end    = (off_x_q == n_last);
        stamp_done = (n_q == 5'd0) || (row_end && (off_y_q == n_last));
        nx_off_x   = row_end ? 5'd0 : off_x_q + 5'd1;
        nx_off_y   = row_end ? off_y_q + 5'd1 : off_y_q;
        // 11-bit sums so pixels past the right/bottom edge are masked, never wrapped.
        sum_x      = {1'b0, base_x_q} + {6'b0, nx_off_x};
        sum_y      = {1'b0, base_y_q} + {6'b0, nx_off_y};
        sum_on     = (sum_x < XLimit) && (sum_y < YLimit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pend_q   <= 3'b000;
            act_q    <= 3'b000;
            base_x_q <= '0;
            base_y_q <= '0;
            n_q      <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            smask_q  <= '0;
            sdata_q  <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
            we_layer <= '0;
        end else begin
            pend_q   <= pend_q | req_bits;
            we_layer <= 3'b000;
            unique case (state_q)
                StIdle: begin
                    if (pend_q != 3'b000) begin
                        state_q  <= StClear;
                        act_q    <= pend_q;
                        pend_q   <= req_bits;
                        wr_x     <= '0;
                        wr_y     <= '0;
                        wr_data  <= ClrVal;
                        we_layer <= pend_q;
                    end else if (stamp_valid && stamp_ready) begin
                        state_q  <= StStamp;
                        base_x_q <= cursor_x;
                        base_y_q <= cursor_y;
                        n_q      <= size_n;
                        smask_q  <= layer_mask;
                        sdata_q  <= acc_data;
                        off_x_q  <= '0;
                        off_y_q  <= '0;
                        if (size_n != 5'd0) begin
                            wr_x     <= cursor_x;
                            wr_y     <= cursor_y;
                            wr_data  <= acc_data;
                            we_layer <= acc_on ? layer_mask : 3'b000;
                        end
                    end
                end
                StClear: begin
                    if (wr_x == XLast && wr_y == YLast) begin
                        state_q <= StIdle;
                    end else begin
                        if (wr_x == XLast) begin
                            wr_x <= '0;
                            wr_y <= wr_y + 10'd1;
                        end else begin
                            wr_x <= wr_x + 10'd1;
                        end
                        we_layer <= act_q;
                    end
                end
                StStamp: begin
                    if (stamp_done) begin
                        state_q <= StIdle;
                    end else begin
                        off_x_q  <= nx_off_x;
                        off_y_q  <= nx_off_y;
                        wr_x     <= sum_x[9:0];
                        wr_y     <= sum_y[9:0];
                        wr_data  <= sdata_q;
                        we_layer <= sum_on ? smask_q : 3'b000;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_write_scheduler.sv
// Scoreboard bench for layer_write_scheduler on a reduced 40x30 frame.
module tb_layer_write_scheduler;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int DW = 4;

    logic          clk;
    logic          reset;
    logic          clear_req;
    logic [2:0]    clear_mask;
    logic          stamp_valid;
    logic          stamp_ready;
    logic [9:0]    cursor_x;
    logic [9:0]    cursor_y;
    logic [1:0]    cursor_size;
    logic [2:0]    layer_mask;
    logic          eraser;
    logic [DW-1:0] pen_data;
    logic [9:0]    wr_x;
    logic [9:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic [2:0]    we_layer;
    logic          busy;

    layer_write_scheduler #(
        .H_RES     (H),
        .V_RES     (V),
        .DATA_W    (DW),
        .CLEAR_VAL (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_req   (clear_req),
        .clear_mask  (clear_mask),
        .stamp_valid (stamp_valid),
        .stamp_ready (stamp_ready),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_size (cursor_size),
        .layer_mask  (layer_mask),
        .eraser      (eraser),
        .pen_data    (pen_data),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .we_layer    (we_layer),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] we;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;
    int   n_wr_seen;
    bit   mon_en;
    bit   busy_low;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One expected entry per cycle while an operation is in flight; empty queue means idle.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (we_layer != 3'b000) n_wr_seen++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("we_layer", 32'(we_layer), 32'(mon_e.we));
                if (mon_e.we != 3'b000) begin
                    check_eq("wr_x", 32'(wr_x), 32'(mon_e.x));
                    check_eq("wr_y", 32'(wr_y), 32'(mon_e.y));
                    check_eq("wr_data", 32'(wr_data), 32'(mon_e.d));
                end
            end else begin
                check_eq("idle_we", 32'(we_layer), 32'd0);
            end
        end
    end

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic push_clear(input logic [2:0] m, input int count);
        exp_t e;
        int   k;
        k = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (k < count) begin
                    e.we = m;
                    e.x  = 10'(x);
                    e.y  = 10'(y);
                    e.d  = 4'd0;
                    exp_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic push_stamp(input int cx, input int cy, input int n, input logic [2:0] m,
                              input logic [3:0] d);
        exp_t e;
        int   x;
        int   y;
        for (int oy = 0; oy < n; oy++) begin
            for (int ox = 0; ox < n; ox++) begin
                x    = cx + ox;
                y    = cy + oy;
                e.we = (x < H && y < V) ? m : 3'b000;
                e.x  = 10'(x);
                e.y  = 10'(y);
                e.d  = d;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic int size_to_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4;
            2'b01:   return 8;
            2'b10:   return 20;
            default: return 0;
        endcase
    endfunction

    task automatic set_stamp(input int cx, input int cy, input logic [1:0] sz,
                             input logic [2:0] m, input logic er, input logic [3:0] pd);
        cursor_x    = 10'(cx);
        cursor_y    = 10'(cy);
        cursor_size = sz;
        layer_mask  = m;
        eraser      = er;
        pen_data    = pd;
        stamp_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_stamp(input int cx, input int cy, input logic [1:0] sz,
                               input logic [2:0] m, input logic er, input logic [3:0] pd);
        int n;
        set_stamp(cx, cy, sz, m, er, pd);
        #1;
        check_eq("ready_before_stamp", 32'(stamp_ready), 32'd1);
        @(posedge clk);
        n = size_to_n(sz);
        if (n == 0) push_idle(1);
        else push_stamp(cx, cy, n, m, er ? 4'd0 : pd);
        #1;
        stamp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        n_wr_seen   = 0;
        mon_en      = 1'b0;
        busy_low    = 1'b0;
        reset       = 1'b1;
        clear_req   = 1'b0;
        clear_mask  = 3'b000;
        stamp_valid = 1'b0;
        cursor_x    = '0;
        cursor_y    = '0;
        cursor_size = 2'b00;
        layer_mask  = 3'b000;
        eraser      = 1'b0;
        pen_data    = '0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(we_layer), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(stamp_ready), 32'd0);
        check_eq("rst_wr_x", 32'(wr_x), 32'd0);
        check_eq("rst_wr_y", 32'(wr_y), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(stamp_ready), 32'd1);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4x4 stamp
        drive_stamp(100, 50, 2'b00, 3'b010, 1'b0, 4'd5);
        @(posedge clk);
        #1;
        check_eq("stamp_busy", 32'(busy), 32'd1);
        check_eq("stamp_not_ready", 32'(stamp_ready), 32'd0);
        wait_drain(40);
        check_eq("stamp_done_ready", 32'(stamp_ready), 32'd1);
        check_eq("stamp_done_busy", 32'(busy), 32'd0);

        // 20x20 eraser stamp straddling the bottom-right corner
        n_wr_seen = 0;
        drive_stamp(30, 25, 2'b10, 3'b111, 1'b1, 4'd9);
        wait_drain(500);
        check_eq("edge_enabled_writes", 32'(n_wr_seen), 32'd50);

        // Stamp whose x-range would wrap past 1023 in 10 bits
        n_wr_seen = 0;
        drive_stamp(1020, 10, 2'b01, 3'b001, 1'b0, 4'd6);
        wait_drain(100);
        check_eq("overflow_writes", 32'(n_wr_seen), 32'd0);

        // No-op size and zero layer mask
        drive_stamp(3, 3, 2'b11, 3'b111, 1'b0, 4'd2);
        wait_drain(10);
        check_eq("noop_ready", 32'(stamp_ready), 32'd1);
        n_wr_seen = 0;
        drive_stamp(3, 3, 2'b00, 3'b000, 1'b0, 4'd2);
        wait_drain(40);
        check_eq("mask0_writes", 32'(n_wr_seen), 32'd0);

        // Clear and stamp in the same cycle: clear wins, stamp follows
        clear_req  = 1'b1;
        clear_mask = 3'b001;
        set_stamp(5, 6, 2'b00, 3'b100, 1'b0, 4'd3);
        #1;
        check_eq("clr_blocks_ready", 32'(stamp_ready), 32'd0);
        @(posedge clk);
        push_idle(1);
        push_clear(3'b001, H * V);
        push_idle(1);
        push_stamp(5, 6, 4, 3'b100, 4'd3);
        #1;
        clear_req = 1'b0;
        repeat (H * V + 2) @(posedge clk);
        #1;
        stamp_valid = 1'b0;
        wait_drain(100);
        check_eq("after_clr_stamp_ready", 32'(stamp_ready), 32'd1);

        // Clears queued behind a stamp and behind a running clear
        drive_stamp(0, 0, 2'b10, 3'b001, 1'b0, 4'd7);
        push_idle(1);
        push_clear(3'b100, H * V);
        push_idle(1);
        push_clear(3'b010, H * V);
        busy_low = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
            if (!busy) busy_low = 1'b1;
            clear_req  = (k == 100) || (k == 600);
            clear_mask = (k == 100) ? 3'b100 : 3'b010;
        end
        clear_req = 1'b0;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("busy_dropped", 32'(busy_low), 32'd0);
        check_eq("chain_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a clear with another clear pending
        clear_req  = 1'b1;
        clear_mask = 3'b001;
        @(posedge clk);
        push_idle(1);
        push_clear(3'b001, 1000);
        for (int k = 1; k <= 1001; k++) begin
            #1;
            clear_req  = (k == 10);
            clear_mask = 3'b010;
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_we", 32'(we_layer), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ready", 32'(stamp_ready), 32'd0);
        check_eq("abort_wr_x", 32'(wr_x), 32'd0);
        check_eq("abort_wr_data", 32'(wr_data), 32'd0);
        check_eq("abort_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("release_ready", 32'(stamp_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("stay_idle_busy", 32'(busy), 32'd0);
        check_eq("stay_idle_ready", 32'(stamp_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
